// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage hazard interface: ID instruction fields in, stall/forward decisions out.
// Latency: none, this is a plain bundle of wires.
// Backpressure: hazard_detected is the stall request back to IF/ID.
interface hazard_scoreboard_unit_if #(
    parameter int REG_AW  = 4,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 16
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_src;
    logic [NUM_SRC-1:0]        id_src_used;
    logic                      id_wb_en;
    logic [REG_AW-1:0]         id_dest;
    logic                      id_mem_rd;
    logic                      pipe_freeze;
    logic                      flush;
    logic                      stat_clr;
    logic                      hazard_detected;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
    logic [CNT_W-1:0]          stall_count;

    modport master (
        output id_valid, id_src, id_src_used, id_wb_en, id_dest, id_mem_rd,
               pipe_freeze, flush, stat_clr,
        input  hazard_detected, fwd_sel, stall_count
    );

    modport slave (
        input  id_valid, id_src, id_src_used, id_wb_en, id_dest, id_mem_rd,
               pipe_freeze, flush, stat_clr,
        output hazard_detected, fwd_sel, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Tracks in-flight destinations (EXE..WB-1) and flags RAW hazards / forwarding selects for ID sources.
// Latency: hazard_detected/fwd_sel combinational same cycle; scoreboard and stall counter update on rising clk.
// Backpressure: hazard_detected stalls IF/ID and pushes a bubble; pipe_freeze holds all state. Option macro: HAZARD_FWD_EN.
module hazard_scoreboard_unit #(
    parameter int REG_AW  = 4,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    hazard_scoreboard_unit_if.slave id_bus
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    // The load flag is only consulted when forwarding resolves everything but load-use.
    typedef struct packed {
        logic              valid;
        logic              wb_en;
        logic [REG_AW-1:0] dest;
`ifdef HAZARD_FWD_EN
        logic              mem_rd;
`endif
    } sb_entry_t;

    sb_entry_t                sb [DEPTH];
    sb_entry_t                push;
    logic                     hazard;
    logic [NUM_SRC-1:0]       hit;
    logic [NUM_SRC*SEL_W-1:0] sel_bus;
    logic [CNT_W-1:0]         stall_cnt;
`ifdef HAZARD_FWD_EN
    logic [SEL_W-1:0]         hit_sel [NUM_SRC];
    logic [NUM_SRC-1:0]       load_use;
`endif

    // Per-source youngest match: scan oldest to youngest so the lowest entry index is written last.
    always_comb begin
        hit = '0;
`ifdef HAZARD_FWD_EN
        load_use = '0;
        for (int i = 0; i < NUM_SRC; i++) hit_sel[i] = '0;
`endif
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (id_bus.id_valid && id_bus.id_src_used[i] && sb[k].valid && sb[k].wb_en &&
                    (sb[k].dest == id_bus.id_src[i*REG_AW +: REG_AW])) begin
                    hit[i] = 1'b1;
`ifdef HAZARD_FWD_EN
                    hit_sel[i]  = SEL_W'(k + 1);
                    load_use[i] = (k == 0) && sb[k].mem_rd;
`endif
                end
            end
        end
    end

`ifdef HAZARD_FWD_EN
    assign hazard = |load_use;

    // Forward from the youngest producer; a load-use stall suppresses all selects.
    always_comb begin
        sel_bus = '0;
        if (!hazard) begin
            for (int i = 0; i < NUM_SRC; i++) sel_bus[i*SEL_W +: SEL_W] = hit_sel[i];
        end
    end
`else
    assign hazard  = |hit;
    assign sel_bus = '0;
`endif

    // Entry-0 candidate: the ID instruction if it advances, otherwise a bubble.
    always_comb begin
        push = '0;
        if (id_bus.id_valid && !hazard && !id_bus.flush) begin
            push.valid  = 1'b1;
            push.wb_en  = id_bus.id_wb_en;
            push.dest   = id_bus.id_dest;
`ifdef HAZARD_FWD_EN
            push.mem_rd = id_bus.id_mem_rd;
`endif
        end
    end

    // Shift the scoreboard one stage per cycle unless the pipeline is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) sb[k] <= '0;
        end else if (!id_bus.pipe_freeze) begin
            sb[0] <= push;
            for (int k = 1; k < DEPTH; k++) sb[k] <= sb[k-1];
        end
    end

    // Saturating count of cycles where a stall actually takes effect; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (id_bus.stat_clr) begin
            stall_cnt <= '0;
        end else if (hazard && !id_bus.pipe_freeze && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign id_bus.hazard_detected = hazard;
    assign id_bus.fwd_sel         = sel_bus;
    assign id_bus.stall_count     = stall_cnt;
endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised hazard detection and forwarding-select unit for the ARM pipeline. It sits beside the ID stage and tracks the destination of every in-flight instruction in an internal shift-register scoreboard of `DEPTH` entries, mirroring EXE..WB-1. Each cycle it compares the ID instruction's used sources against that scoreboard. It produces a stall request, per-source forwarding selects and a saturating stall-cycle counter.

## Interface
Parameters:
- `REG_AW`, 4, register address width.
- `NUM_SRC`, 2, number of source operands checked per instruction.
- `DEPTH`, 2, tracked in-flight stages; entry 0 = EXE, entry 1 = MEM, and so on.
- `CNT_W`, 16, stall counter width.
- `SEL_W`, derived as clog2(`DEPTH`+1), forwarding select width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_src` in `NUM_SRC`*`REG_AW`: source addresses; source i occupies bits [i*`REG_AW` +: `REG_AW`].
- `id_src_used` in `NUM_SRC`: per-source "operand actually read" (generalises Two_src).
- `id_wb_en` in 1: ID instruction writes a register.
- `id_dest` in `REG_AW`: ID destination.
- `id_mem_rd` in 1: ID instruction is a load.
- `pipe_freeze` in 1: whole pipeline frozen (memory wait).
- `flush` in 1: branch taken; ID instruction is killed.
- `stat_clr` in 1: synchronous clear of `stall_count`.
- `hazard_detected` out 1: stall IF/ID and insert a bubble.
- `fwd_sel` out `NUM_SRC`*`SEL_W`: per source, 0 = register file, k = entry k-1.
- `stall_count` out `CNT_W`: saturating count of stall cycles.

## Operation
- Scoreboard entry fields: {valid, wb_en, dest, mem_rd}.
- Match(i,k) = `id_valid` & `id_src_used`[i] & entry[k].valid & entry[k].wb_en & (entry[k].dest == src i).
- Youngest (lowest k) match wins for source i.
- Push value for entry 0:
  - When `id_valid` & ~`hazard_detected` & ~`flush`: {1, `id_wb_en`, `id_dest`, `id_mem_rd`}.
  - Otherwise: a bubble (valid=0).
- Update priority is `rst_n` > `pipe_freeze` > normal:
  - Frozen: all entries hold, and `flush` is ignored. The flush source must hold `flush` until the freeze ends.
  - Normal: entry[k] <= entry[k-1]; entry[0] <= push value; entry[`DEPTH`-1] retires.
- `stall_count`:
  - `stat_clr` clears it to 0 (clear has priority).
  - Otherwise it increments when `hazard_detected` & ~`pipe_freeze`.
  - It saturates at all-ones and never wraps.
- Sources with `id_src_used`=0 never cause a hazard, whatever their address.
- Register 0 gets no special treatment.

## Timing
- `hazard_detected` and `fwd_sel` are combinational from ID inputs and registered entries; they are valid in the same cycle.
- Scoreboard and counter update on the rising `clk` edge.
- Reset values: all entries valid=0, `hazard_detected`=0 (no valid entries), `fwd_sel`=0, `stall_count`=0.
- Reset asserted mid-operation clears all entries immediately (asynchronous), independent of `pipe_freeze`.
- Simultaneous `flush` and hazard: a bubble is pushed. `hazard_detected` still reflects the comparison; the counter still increments.
- A dependent instruction stalls at most `DEPTH` cycles (non-forwarding) or exactly 1 cycle (load-use, forwarding).

## Configuration
Macro: `HAZARD_FWD_EN`.
- Defined:
  - `hazard_detected` = 1 only when some source's youngest match is entry 0 with mem_rd=1 (load-use).
  - Otherwise `fwd_sel`[i] = k+1 for the youngest match k.
  - `fwd_sel` is forced to 0 in any cycle where `hazard_detected`=1.
- Undefined:
  - `hazard_detected` = OR of all Match(i,k).
  - `fwd_sel` is tied to 0.

## Test plan
- Reset mid-run: scoreboard holds R3 in entry 0, then `rst_n`=0 -> entries cleared at once; `hazard_detected`=0 and `stall_count`=0 while src R3 is presented.
- No FWD: issue dest R3 with wb_en=1, then src1=R3 used -> `hazard_detected`=1 for 2 cycles, 0 on the 3rd; `stall_count`=2.
- FWD ALU: issue dest R5 (no load), then src2=R5 -> hazard 0 and `fwd_sel`[1]=1; re-present the same source one cycle later after a bubble -> `fwd_sel`[1]=2.
- FWD load-use: load to R7, then src1=R7 -> hazard 1 for exactly 1 cycle with `fwd_sel`=0; next cycle hazard 0 and `fwd_sel`[0]=2.
- Freeze: R4 in entry 0, `pipe_freeze`=1 for 3 cycles while src=R4 stalls -> entries unchanged, `stall_count` unchanged; release -> normal shifting resumes.
- Flush and unused source: `id_valid` with dest R2 and `flush`=1 -> bubble, so next src R2 gives hazard 0; separately, src2=R3 with `id_src_used`[1]=0 and R3 in flight -> hazard 0.
